// File: rtl/bit_serializer.sv
// Parallel-to-serial frame transmitter with a one-cycle load latency and back-to-back frame support.
// Define SER_PARITY_EN to append an even-parity bit after the data bits of every frame.
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   MSB_FIRST  = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             frame_done
);

  // state  | meaning
  // IDLE   | no frame in progress, ser_out at IDLE_LEVEL, ready for a word
  // SHIFT  | a data bit is on ser_out; cnt is its index within the frame
  // PARITY | even-parity bit is on ser_out (SER_PARITY_EN builds only)
`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             ser_out_n, ser_valid_n, busy_n, frame_done_n, load_ready_n;
  logic             accept, start;
`ifdef SER_PARITY_EN
  logic             par, par_n;
`endif

  assign accept = load_valid && load_ready;

  always_comb begin
    state_n      = state;
    shreg_n      = shreg;
    cnt_n        = cnt;
    ser_out_n    = IDLE_LEVEL;
    ser_valid_n  = 1'b0;
    busy_n       = 1'b0;
    frame_done_n = 1'b0;
    load_ready_n = 1'b1;
    start        = 1'b0;
`ifdef SER_PARITY_EN
    par_n        = par;
`endif

    case (state)
      S_SHIFT: begin
        if (cnt != LAST) begin
          ser_out_n   = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
          shreg_n     = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                         : {1'b0, shreg[WIDTH-1:1]};
          cnt_n       = cnt + CW'(1);
          ser_valid_n = 1'b1;
          busy_n      = 1'b1;
`ifdef SER_PARITY_EN
          load_ready_n = 1'b0;
`else
          // the bit being registered now is the last one of the frame
          frame_done_n = (cnt_n == LAST);
          load_ready_n = (cnt_n == LAST);
`endif
        end else begin
`ifdef SER_PARITY_EN
          state_n      = S_PARITY;
          ser_out_n    = par;
          ser_valid_n  = 1'b1;
          busy_n       = 1'b1;
          frame_done_n = 1'b1;
          load_ready_n = 1'b1;
`else
          if (accept) start = 1'b1;
          else        state_n = S_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      S_PARITY: begin
        if (accept) start = 1'b1;
        else        state_n = S_IDLE;
      end
`endif
      default: begin
        state_n = S_IDLE;
        if (accept) start = 1'b1;
      end
    endcase

    // new word: first bit goes straight to the output register
    if (start) begin
      state_n      = S_SHIFT;
      cnt_n        = '0;
      ser_out_n    = (MSB_FIRST != 0) ? data_in[WIDTH-1] : data_in[0];
      shreg_n      = (MSB_FIRST != 0) ? {data_in[WIDTH-2:0], 1'b0}
                                      : {1'b0, data_in[WIDTH-1:1]};
      ser_valid_n  = 1'b1;
      busy_n       = 1'b1;
      frame_done_n = 1'b0;
      load_ready_n = 1'b0;
`ifdef SER_PARITY_EN
      par_n        = ^data_in;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      cnt        <= '0;
      ser_out    <= IDLE_LEVEL;
      ser_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      load_ready <= 1'b1;
`ifdef SER_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      ser_out    <= ser_out_n;
      ser_valid  <= ser_valid_n;
      busy       <= busy_n;
      frame_done <= frame_done_n;
      load_ready <= load_ready_n;
`ifdef SER_PARITY_EN
      par        <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: MSB-first instance for most vectors, LSB-first instance for bit order.
// Expected frame length follows SER_PARITY_EN.
module tb_bit_serializer;

`ifdef SER_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in, d1;
  logic       load_valid, lv1;
  logic       load_ready, ser_out, ser_valid, busy, frame_done;
  logic       lr1, so1, sv1, bz1, fd1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .frame_done(frame_done));

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .data_in(d1), .load_valid(lv1),
    .load_ready(lr1), .ser_out(so1), .ser_valid(sv1),
    .busy(bz1), .frame_done(fd1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] w);
    data_in    = w;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  function automatic logic exp_bit(input logic [7:0] w, input int i, input bit msb);
    if (i == 8) return ^w;
    return msb ? w[7-i] : w[i];
  endfunction

  // Walks one frame from its first bit; optional injection of 8'hFF while busy, optional chained word.
  task automatic check_frame(input string tag, input logic [7:0] w, input bit inj,
                             input bit b2b, input logic [7:0] w2);
    for (int i = 0; i < FL; i++) begin
      chk({tag, "_bit"},   32'(ser_out),    32'(exp_bit(w, i, 1'b1)));
      chk({tag, "_valid"}, 32'(ser_valid),  32'd1);
      chk({tag, "_busy"},  32'(busy),       32'd1);
      chk({tag, "_done"},  32'(frame_done), 32'(i == FL - 1));
      chk({tag, "_ready"}, 32'(load_ready), 32'(i == FL - 1));
      if (inj && i >= 3 && i <= 5) begin
        data_in = 8'hFF; load_valid = 1'b1;
      end else if (b2b && i == FL - 1) begin
        data_in = w2; load_valid = 1'b1;
      end else begin
        load_valid = 1'b0;
      end
      tick();
    end
    load_valid = 1'b0;
    if (!b2b) begin
      chk({tag, "_idle_valid"}, 32'(ser_valid),  32'd0);
      chk({tag, "_idle_out"},   32'(ser_out),    32'd0);
      chk({tag, "_idle_busy"},  32'(busy),       32'd0);
      chk({tag, "_idle_done"},  32'(frame_done), 32'd0);
      chk({tag, "_idle_ready"}, 32'(load_ready), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; data_in = 8'h00; load_valid = 1'b0; d1 = 8'h00; lv1 = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(ser_valid),  32'd0);
    chk("rst_out",   32'(ser_out),    32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    rst = 1'b0;
    tick();
    chk("rel_ready", 32'(load_ready), 32'd1);
    chk("rel_valid", 32'(ser_valid),  32'd0);

    accept(8'hB0);
    check_frame("b0", 8'hB0, 1'b0, 1'b0, 8'h00);
    tick();

    accept(8'hB0);
    check_frame("b2b_a", 8'hB0, 1'b0, 1'b1, 8'h0B);
    check_frame("b2b_b", 8'h0B, 1'b0, 1'b0, 8'h00);

    accept(8'h5A);
    check_frame("ign", 8'h5A, 1'b1, 1'b0, 8'h00);

    accept(8'hB0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_bit", 32'(ser_out), 32'(exp_bit(8'hB0, i, 1'b1)));
      tick();
    end
    rst = 1'b1; data_in = 8'hFF; load_valid = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(ser_valid),  32'd0);
    chk("mid_rst_out",   32'(ser_out),    32'd0);
    chk("mid_rst_busy",  32'(busy),       32'd0);
    chk("mid_rst_ready", 32'(load_ready), 32'd1);
    chk("mid_rst_done",  32'(frame_done), 32'd0);
    rst = 1'b0; load_valid = 1'b0;
    for (int i = 0; i < FL + 1; i++) begin
      tick();
      chk("post_rst_valid", 32'(ser_valid),  32'd0);
      chk("post_rst_done",  32'(frame_done), 32'd0);
    end

    d1 = 8'h0D; lv1 = 1'b1;
    tick();
    lv1 = 1'b0;
    for (int i = 0; i < FL; i++) begin
      chk("lsb_bit",   32'(so1), 32'(exp_bit(8'h0D, i, 1'b0)));
      chk("lsb_valid", 32'(sv1), 32'd1);
      chk("lsb_done",  32'(fd1), 32'(i == FL - 1));
      tick();
    end
    chk("lsb_idle", 32'(sv1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
